// File: rtl/pacman_move_if.sv
// Wall-map query port: the mover asks whether a candidate pixel is a wall,
// the map answers with a one-cycle acknowledge carrying the verdict.
`timescale 1ns/1ps
interface pacman_move_if;
  logic       q_req;
  logic [8:0] q_x;
  logic [8:0] q_y;
  logic       q_wall;
  logic       q_ack;

  modport master (output q_req, q_x, q_y, input q_wall, q_ack);
  modport slave  (input q_req, q_x, q_y, output q_wall, q_ack);
endinterface

// File: rtl/pacman_move.sv
// Pacman player movement: button conditioning, buffered turn request and a
// one-pixel-per-step mover that checks every candidate pixel against the maze
// wall map before committing to it.
`timescale 1ns/1ps
module pacman_move #(
  parameter int START_X    = 240,
  parameter int START_Y    = 240,
  parameter int X_MIN      = 16,
  parameter int X_MAX      = 464,
  parameter int Y_MIN      = 16,
  parameter int Y_MAX      = 464,
  parameter int STEP_DIV   = 10,
  parameter int DEB_TICKS  = 8,
  parameter int TILE_SHIFT = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                tick,
  input  logic [3:0]          btn,
  pacman_move_if.master       wall,
  output logic [8:0]          p_x,
  output logic [8:0]          p_y,
  output logic [1:0]          dir,
  output logic                moving
);

  localparam logic [1:0] D_UP = 2'd0, D_DOWN = 2'd1, D_LEFT = 2'd2, D_RIGHT = 2'd3;
  localparam int DW = (DEB_TICKS > 1) ? $clog2(DEB_TICKS) : 1;
  localparam int SW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_TICKS - 1);
  localparam logic [SW-1:0] STEP_LAST = SW'(STEP_DIV - 1);
  localparam logic [8:0] X_MIN9 = 9'(X_MIN), X_MAX9 = 9'(X_MAX);
  localparam logic [8:0] Y_MIN9 = 9'(Y_MIN), Y_MAX9 = 9'(Y_MAX);
  localparam logic [8:0] START_X9 = 9'(START_X), START_Y9 = 9'(START_Y);

  typedef enum logic [2:0] {
    S_IDLE, S_TRY_TURN, S_WAIT_TURN, S_TRY_FWD, S_WAIT_FWD, S_MOVE
  } state_t;

  state_t          state;
  logic [1:0]      tick_sync;
  logic            tick_d, tick_p;
  logic [3:0]      btn_m, btn_s, btn_acc;
  logic [DW-1:0]   deb_cnt [4];
  logic [3:0]      press;
  logic            press_any;
  logic [1:0]      press_dir;
  logic [SW-1:0]   step_cnt;
  logic            step_wrap, step_pend;
  logic            req_v;
  logic [1:0]      req_dir, cand_dir, try_dir;
  logic            eff_req_v;
  logic [1:0]      eff_req_dir;
  logic            aligned;
  logic [8:0]      cand_x, cand_y;
  logic            cand_ok;

  // Synchronize tick and buttons, and turn the tick rise into a one-cycle pulse.
  // NOTE: registers take non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tick_sync <= '0;
      tick_d    <= 1'b0;
      tick_p    <= 1'b0;
      btn_m     <= '0;
      btn_s     <= '0;
    end else begin
      tick_sync <= {tick_sync[0], tick};
      tick_d    <= tick_sync[1];
      tick_p    <= tick_sync[1] & ~tick_d;
      btn_m     <= btn;
      btn_s     <= btn_m;
    end
  end

  // Press detection, priority encode and the effective request seen by a step.
  // NOTE: every combinational output is defaulted first so no path can infer a latch.
  always_comb begin
    press     = '0;
    press_dir = D_UP;
    for (int i = 0; i < 4; i++)
      press[i] = tick_p && btn_s[i] && !btn_acc[i] && (deb_cnt[i] == DEB_LAST);
    for (int i = 3; i >= 0; i--)
      if (press[i]) press_dir = 2'(i);
    press_any   = |press;
    eff_req_v   = press_any | req_v;
    eff_req_dir = press_any ? press_dir : req_dir;
    aligned     = (p_x[TILE_SHIFT-1:0] == '0) && (p_y[TILE_SHIFT-1:0] == '0);
    step_wrap   = tick_p && (step_cnt == STEP_LAST);
  end

  // Candidate pixel one step along the direction being tried, range-checked first.
  always_comb begin
    try_dir = (state == S_TRY_TURN) ? cand_dir : dir;
    cand_x  = p_x;
    cand_y  = p_y;
    cand_ok = 1'b0;
    case (try_dir)
      D_UP:    begin cand_ok = (p_y > Y_MIN9); cand_y = p_y - 9'd1; end
      D_DOWN:  begin cand_ok = (p_y < Y_MAX9); cand_y = p_y + 9'd1; end
      D_LEFT:  begin cand_ok = (p_x > X_MIN9); cand_x = p_x - 9'd1; end
      default: begin cand_ok = (p_x < X_MAX9); cand_x = p_x + 9'd1; end
    endcase
  end

  // Debounce: a level must differ from the accepted one for DEB_TICKS samples in a row.
  // NOTE: this small counter array is plain flops, so it is reset like any other register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      btn_acc <= '0;
      for (int i = 0; i < 4; i++) deb_cnt[i] <= '0;
    end else if (tick_p) begin
      for (int i = 0; i < 4; i++) begin
        if (btn_s[i] == btn_acc[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DEB_LAST) begin
          btn_acc[i] <= btn_s[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + 1'b1;
        end
      end
    end
  end

  // Step timer, turn request buffer and the movement FSM with its registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      step_cnt   <= '0;
      step_pend  <= 1'b0;
      req_v      <= 1'b0;
      req_dir    <= D_UP;
      cand_dir   <= D_LEFT;
      dir        <= D_LEFT;
      p_x        <= START_X9;
      p_y        <= START_Y9;
      moving     <= 1'b0;
      wall.q_req <= 1'b0;
      wall.q_x   <= START_X9;
      wall.q_y   <= START_Y9;
    end else begin
      if (tick_p) step_cnt <= step_wrap ? '0 : step_cnt + 1'b1;
      if (step_wrap) step_pend <= 1'b1;
      if (press_any) begin
        req_v   <= 1'b1;
        req_dir <= press_dir;
      end
      case (state)
        S_IDLE: if (step_pend) begin
          step_pend <= step_wrap;
          if (eff_req_v && eff_req_dir == dir) begin
            req_v <= 1'b0;
            state <= S_TRY_FWD;
          end else if (eff_req_v && (eff_req_dir == (dir ^ 2'b01) || aligned)) begin
            cand_dir <= eff_req_dir;
            state    <= S_TRY_TURN;
          end else begin
            state <= S_TRY_FWD;
          end
        end
        S_TRY_TURN, S_TRY_FWD: begin
          if (cand_ok) begin
            wall.q_x   <= cand_x;
            wall.q_y   <= cand_y;
            wall.q_req <= 1'b1;
            state      <= (state == S_TRY_TURN) ? S_WAIT_TURN : S_WAIT_FWD;
          end else if (state == S_TRY_TURN) begin
            state <= S_TRY_FWD;
          end else begin
            moving <= 1'b0;
            state  <= S_IDLE;
          end
        end
        S_WAIT_TURN: if (wall.q_ack) begin
          wall.q_req <= 1'b0;
          if (!wall.q_wall) begin
            dir <= cand_dir;
            if (!press_any) req_v <= 1'b0;
            state <= S_MOVE;
          end else begin
            state <= S_TRY_FWD;
          end
        end
        S_WAIT_FWD: if (wall.q_ack) begin
          wall.q_req <= 1'b0;
          if (!wall.q_wall) begin
            state <= S_MOVE;
          end else begin
            moving <= 1'b0;
            state  <= S_IDLE;
          end
        end
        S_MOVE: begin
          p_x    <= wall.q_x;
          p_y    <= wall.q_y;
          moving <= 1'b1;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/pacman_move.md
# pacman_move

Player-movement stage for the Pacman game: conditions the four raw push-buttons, keeps a buffered turn request, and advances the Pacman sprite position one pixel per movement step, consulting the maze wall map through a request/acknowledge port. It sits upstream of `graphic` and the monster chasers, supplying `p_x`/`p_y`. It is paced by the 1 ms tick from `timer1ms`, which it uses as an enable within the single `clk` domain.

## Interface
- `START_X`, 240: reset X position (pixels)
- `START_Y`, 240: reset Y position
- `X_MIN` / `X_MAX`, 16 / 464: inclusive X travel limits
- `Y_MIN` / `Y_MAX`, 16 / 464: inclusive Y travel limits
- `STEP_DIV`, 10: tick pulses per movement step (≥1)
- `DEB_TICKS`, 8: consecutive stable ticks to accept a button level (≥1)
- `TILE_SHIFT`, 4: log2 of tile size; perpendicular turns are allowed only on tile-aligned positions
- `clk`  input  1  system clock, the only clock
- `reset`  input  1  asynchronous, active-low reset
- `tick`  input  1  1 ms timer level from `timer1ms`; asynchronous to the logic, synchronized internally
- `btn`  input  4  raw active-high buttons: [0] up, [1] down, [2] left, [3] right
- `q_wall`  input  1  wall-map answer; valid when `q_ack`=1
- `q_ack`  input  1  wall-map acknowledge, 1-cycle pulse
- `q_req`  output  1  wall-map query request
- `q_x`, `q_y`  output  9 each  candidate pixel position being queried
- `p_x`, `p_y`  output  9 each  current Pacman position
- `dir`  output  2  current heading: 0 up, 1 down, 2 left, 3 right
- `moving`  output  1  1 when the last step succeeded; 0 when blocked or before the first step

## Operation
- Synchronization: 2-flop synchronizers on `tick` and each `btn` bit. A rising edge of synchronized `tick` gives `tick_p`, exactly one `clk` wide.
- Debounce: one counter per button, sampled on `tick_p`. A level that differs from the accepted level for `DEB_TICKS` consecutive samples becomes the accepted level. Any sample matching the accepted level clears the counter.
- Press event: an accepted 0→1 transition latches `req_dir` and sets `req_v`. If several buttons have press events in the same cycle, priority is up > down > left > right.
- Step timer: counts `tick_p` from 0 to `STEP_DIV-1`. At wrap it raises `step_pend`. At most one step can be pending; a wrap while `step_pend`=1 is dropped.
- FSM states:
  - IDLE: on `step_pend`, clear it. Go to TRY_TURN if `req_v` and (`req_dir` is the reverse of `dir`, or both low `TILE_SHIFT` bits of `p_x` and `p_y` are zero). Otherwise go to TRY_FWD.
  - TRY_TURN: form the candidate = `p` ±1 along `req_dir`.
    - Candidate outside [MIN,MAX] counts as a wall; go to TRY_FWD with no query.
    - Otherwise raise `q_req` and go to WAIT_TURN.
  - WAIT_TURN: on `q_ack`, drop `q_req`.
    - `q_wall`=0: `dir`←`req_dir`, clear `req_v`, go to MOVE.
    - `q_wall`=1: go to TRY_FWD; `req_v` stays set, so the request is retried on later steps.
  - TRY_FWD / WAIT_FWD: same as TRY_TURN / WAIT_TURN, but along `dir`.
    - Free: go to MOVE.
    - Blocked or out of range: `moving`←0, return to IDLE.
  - MOVE: `p_x`/`p_y`←candidate, `moving`←1, return to IDLE.
- A reverse request is taken even when not aligned. A request equal to `dir` just clears `req_v` and behaves as forward.
- Arithmetic: unsigned 9-bit. Range checks happen before the ±1, so underflow and overflow cannot occur.

## Timing
- Reset (asynchronous, immediate) values:
  - `p_x`=`START_X`, `p_y`=`START_Y`, `dir`=2 (left)
  - `moving`=0, `q_req`=0, `q_x`=`START_X`, `q_y`=`START_Y`
  - `req_v`=0, `step_pend`=0, all counters 0, accepted button levels 0, FSM in IDLE
- Reset asserted mid-handshake drops `q_req` at once. A late `q_ack` arriving after reset is ignored because the FSM is in IDLE.
- Query handshake:
  - `q_req` rises one cycle after entering TRY_* and holds until the cycle `q_ack` is sampled high.
  - `q_x`/`q_y` are stable for the whole time `q_req` is high.
  - `q_ack` while `q_req`=0 is ignored.
  - Any acknowledge latency ≥1 cycle is legal.
- Latencies:
  - `tick` edge → `tick_p`: 3 cycles.
  - `step_pend` → position update, with 1-cycle acknowledge: 4 cycles forward-only, 7 cycles for a failed turn followed by a forward move.
- A press event and a step arriving in the same cycle: the new `req_dir` is used by that step.

## Test plan
- Reset release, no buttons, wall map always free, `STEP_DIV`=2 → after 4 tick edges `p_x`=238, `p_y`=240, `dir`=2, `moving`=1.
- Hold btn[0] for 9 ticks from (240,240) → `req_v` set after the 8th stable tick; the next step yields `dir`=0, `p_y`=239.
- Btn[0] pressed at unaligned (237,240) with no wall → no turn, X keeps decrementing. At `p_x`=224 the turn is taken and `p_y`=239.
- `q_wall`=1 for every query → `p` unchanged, `moving`=0, `q_req` pulses once per step and is held until `q_ack` (test acknowledge delays of 1 and 5 cycles).
- `p_x`=`X_MIN`=16 heading left → no `q_req`, `moving`=0, `p_x` stays 16.
- Assert `reset` while `q_req`=1 → `q_req`=0 in the same cycle, outputs return to reset values, and a stray `q_ack` has no effect.
